// File: rtl/t04_uart_rx_param_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package t04_uart_pkg;

   // Receiver frame states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } rx_state_t;

   // Parity modes.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // xor_all is the XOR of the payload and the received parity bit.
   // Even mode wants 0, odd mode wants 1; anything else is a mismatch.
   function automatic logic parity_bad(input logic xor_all, input int mode);
      return (mode == PAR_ODD) ? ~xor_all : xor_all;
   endfunction

endpackage

// File: rtl/t04_uart_rx_param_if.sv
// Read-strobe and status interface between the UART receiver and its consumer.
interface t04_uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_en;
   logic                 clr_err;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic                 fifo_full;
   logic                 busy;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   // Consumer side: strobes reads and clears, observes data and status.
   modport master (
      output rd_en, clr_err,
      input  rd_data, rd_valid, fifo_full, busy, frame_err, parity_err, overrun
   );

   // Receiver side.
   modport slave (
      input  rd_en, clr_err,
      output rd_data, rd_valid, fifo_full, busy, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/t04_uart_rx_param_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop together succeed even when full.
module t04_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
   assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};

   // Head is presented combinationally; forced to zero when empty so it reads 0 out of reset.
   assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

   // Pointer registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage array write port.
   // NOTE: the array is deliberately not reset; contents are qualified by the pointers, and leaving it out of reset keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/t04_uart_rx_param.sv
// Parametrised UART receiver: synchroniser, baud/bit counters, frame FSM,
// sticky error flags and a FWFT receive FIFO behind a read-strobe interface.
module t04_uart_rx_param
   import t04_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 rx_in,
   t04_uart_rx_param_if.slave   bus
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   rx_state_t              state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d;     // pending parity error for the current frame
   logic                   ferr_q, ferr_d;     // pending framing error for the current frame
   logic                   frame_err_q, frame_err_d;
   logic                   parity_err_q, parity_err_d;
   logic                   overrun_q, overrun_d;

   logic                   ferr_now;
   logic                   set_ferr;
   logic                   set_perr;
   logic                   frame_good;
   logic                   set_ovr;

   logic [DATA_BITS-1:0]   fifo_dout;
   logic                   fifo_empty;
   logic                   fifo_full;

   // Input synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   // Frame FSM register and its counters/shift register.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Frame FSM next state: counts to mid-bit, samples, and resolves the frame on the last stop sample.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ferr_now   = ferr_q;
      set_ferr   = 1'b0;
      set_perr   = 1'b0;
      frame_good = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               baud_d  = BAUD_HALF;
               bit_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end

         S_START: begin
            if (baud_q == '0) begin
               if (rxs) begin
                  // Glitch shorter than half a bit: quietly abandon.
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  baud_d  = BAUD_FULL;
                  bit_d   = '0;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end

         S_DATA: begin
            if (baud_q == '0) begin
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               baud_d  = BAUD_FULL;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end

         S_PARITY: begin
            if (baud_q == '0) begin
               perr_d  = parity_bad(^shift_q ^ rxs, PARITY);
               baud_d  = BAUD_FULL;
               bit_d   = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end

         S_STOP: begin
            if (baud_q == '0) begin
               ferr_now = ferr_q | ~rxs;
               ferr_d   = ferr_now;
               baud_d   = BAUD_FULL;
               if (bit_q == LAST_STOP) begin
                  bit_d = '0;
                  if (ferr_now) begin
                     set_ferr = 1'b1;
                     state_d  = S_WAIT_IDLE;
                  end else begin
                     if (perr_q) begin
                        set_perr = 1'b1;
                     end else begin
                        frame_good = 1'b1;
                     end
                     // Straight back to IDLE so a start edge right after mid-stop is caught.
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end

         S_WAIT_IDLE: begin
            // A held-low line (break) must return high before a new frame can start.
            if (rxs) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A good frame arriving at a full FIFO is lost unless the consumer pops in the same cycle.
   assign set_ovr = frame_good & fifo_full & ~bus.rd_en;

   // Sticky flags: a new error in the same cycle as clr_err wins.
   always_comb begin
      frame_err_d  = set_ferr | (frame_err_q  & ~bus.clr_err);
      parity_err_d = set_perr | (parity_err_q & ~bus.clr_err);
      overrun_d    = set_ovr  | (overrun_q    & ~bus.clr_err);
   end

   // Sticky flag registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   t04_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .nRst  (nRst),
      .push  (frame_good),
      .pop   (bus.rd_en),
      .din   (shift_q),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.rd_data    = fifo_dout;
   assign bus.rd_valid   = ~fifo_empty;
   assign bus.fifo_full  = fifo_full;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.frame_err  = frame_err_q;
   assign bus.parity_err = parity_err_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_t04_uart_rx_param.sv
// Self-checking bench: two receivers (no parity / even parity), scoreboard of expected bytes.
module tb_t04_uart_rx_param;
   localparam int CPB = 8;

   logic clk = 1'b0;
   logic nRst;
   logic rx0, rx1;

   always #5 clk = ~clk;

   t04_uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
   t04_uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

   t04_uart_rx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
      .FIFO_DEPTH(4), .SYNC_STAGES(2)
   ) dut0 (
      .clk(clk), .nRst(nRst), .rx_in(rx0), .bus(bus0.slave)
   );

   t04_uart_rx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
      .FIFO_DEPTH(4), .SYNC_STAGES(2)
   ) dut1 (
      .clk(clk), .nRst(nRst), .rx_in(rx1), .bus(bus1.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic get_valid(input int w);
      return (w == 0) ? bus0.rd_valid : bus1.rd_valid;
   endfunction

   function automatic logic [7:0] get_data(input int w);
      return (w == 0) ? bus0.rd_data : bus1.rd_data;
   endfunction

   function automatic logic get_busy(input int w);
      return (w == 0) ? bus0.busy : bus1.busy;
   endfunction

   function automatic logic get_full(input int w);
      return (w == 0) ? bus0.fifo_full : bus1.fifo_full;
   endfunction

   // {frame_err, parity_err, overrun}
   function automatic logic [2:0] get_flags(input int w);
      return (w == 0) ? {bus0.frame_err, bus0.parity_err, bus0.overrun}
                      : {bus1.frame_err, bus1.parity_err, bus1.overrun};
   endfunction

   function automatic void sb_push(input int w, input logic [7:0] d);
      if (w == 0) exp0.push_back(d); else exp1.push_back(d);
   endfunction

   function automatic int sb_size(input int w);
      return (w == 0) ? exp0.size() : exp1.size();
   endfunction

   function automatic logic [7:0] sb_pop(input int w);
      return (w == 0) ? exp0.pop_front() : exp1.pop_front();
   endfunction

   task automatic set_rx(input int w, input logic v);
      if (w == 0) rx0 = v; else rx1 = v;
   endtask

   task automatic set_rd_en(input int w, input logic v);
      if (w == 0) bus0.rd_en = v; else bus1.rd_en = v;
   endtask

   task automatic pulse_clr(input int w);
      if (w == 0) bus0.clr_err = 1'b1; else bus1.clr_err = 1'b1;
      @(negedge clk);
      bus0.clr_err = 1'b0;
      bus1.clr_err = 1'b0;
   endtask

   // Drives one frame; optionally pops the FIFO in the cycle the frame resolves (mid-stop + sync delay).
   task automatic send_frame(input int w, input logic [7:0] data, input int par_mode,
                             input logic par_flip, input logic stop_val, input bit pop_in_stop);
      logic pb;
      set_rx(w, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(w, data[i]);
         repeat (CPB) @(negedge clk);
      end
      if (par_mode != 0) begin
         pb = (^data) ^ (par_mode == 2) ^ par_flip;
         set_rx(w, pb);
         repeat (CPB) @(negedge clk);
      end
      set_rx(w, stop_val);
      for (int c = 0; c < CPB; c++) begin
         if (pop_in_stop && c == 6) begin
            check("pop_in_push_sbq", sb_size(w) > 0, 1'b1);
            if (sb_size(w) > 0) check("pop_in_push_data", get_data(w), sb_pop(w));
            set_rd_en(w, 1'b1);
         end
         if (pop_in_stop && c == 7) set_rd_en(w, 1'b0);
         @(negedge clk);
      end
      set_rx(w, 1'b1);
   endtask

   // Waits (bounded) for a FIFO head, compares against the scoreboard, then pops it.
   task automatic read_check(input int w, input string tag);
      int cnt;
      cnt = 0;
      while (!get_valid(w) && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, "_valid"}, get_valid(w), 1'b1);
      if (get_valid(w)) begin
         check({tag, "_sbq"}, sb_size(w) > 0, 1'b1);
         if (sb_size(w) > 0) check({tag, "_data"}, get_data(w), sb_pop(w));
         set_rd_en(w, 1'b1);
         @(negedge clk);
         set_rd_en(w, 1'b0);
      end
   endtask

   initial begin
      nRst = 1'b0;
      rx0 = 1'b1;
      rx1 = 1'b1;
      bus0.rd_en = 1'b0;
      bus0.clr_err = 1'b0;
      bus1.rd_en = 1'b0;
      bus1.clr_err = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_valid", get_valid(0), 1'b0);
      check("rst_full",  get_full(0), 1'b0);
      check("rst_data",  get_data(0), 8'h00);
      check("rst_busy",  get_busy(0), 1'b0);
      check("rst_flags", get_flags(0), 3'b000);
      nRst = 1'b1;
      repeat (4) @(negedge clk);

      // 1: back-to-back frames
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b0); sb_push(0, 8'hA5);
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1'b0); sb_push(0, 8'h3C);
      read_check(0, "b2b_first");
      read_check(0, "b2b_second");
      check("b2b_empty", get_valid(0), 1'b0);
      check("b2b_flags", get_flags(0), 3'b000);
      check("b2b_idle",  get_busy(0), 1'b0);

      // 2: false start
      set_rx(0, 1'b0);
      repeat (3) @(negedge clk);
      set_rx(0, 1'b1);
      check("fs_busy_during", get_busy(0), 1'b1);
      repeat (12) @(negedge clk);
      check("fs_busy_after", get_busy(0), 1'b0);
      check("fs_empty", get_valid(0), 1'b0);
      check("fs_flags", get_flags(0), 3'b000);

      // 3: even parity good then bad
      send_frame(1, 8'h07, 1, 1'b0, 1'b1, 1'b0); sb_push(1, 8'h07);
      send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check("par_flags", get_flags(1), 3'b010);
      read_check(1, "par_good");
      check("par_one_entry", get_valid(1), 1'b0);
      pulse_clr(1);
      check("par_cleared", get_flags(1), 3'b000);

      // 4: framing error followed by a long break
      send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1'b0);
      set_rx(0, 1'b0);
      repeat (30 * CPB) @(negedge clk);
      check("fe_flags", get_flags(0), 3'b100);
      check("fe_no_push", get_valid(0), 1'b0);
      check("fe_wait_idle", get_busy(0), 1'b1);
      set_rx(0, 1'b1);
      repeat (6) @(negedge clk);
      check("fe_idle", get_busy(0), 1'b0);
      check("fe_no_push2", get_valid(0), 1'b0);
      pulse_clr(0);
      check("fe_cleared", get_flags(0), 3'b000);

      // 5a: overrun on the fifth frame
      for (int i = 1; i <= 5; i++) begin
         send_frame(0, 8'(i), 0, 1'b0, 1'b1, 1'b0);
         if (i <= 4) sb_push(0, 8'(i));
      end
      repeat (2) @(negedge clk);
      check("ovr_full", get_full(0), 1'b1);
      check("ovr_flags", get_flags(0), 3'b001);
      for (int i = 0; i < 4; i++) read_check(0, "ovr_drain");
      check("ovr_empty", get_valid(0), 1'b0);
      pulse_clr(0);
      check("ovr_cleared", get_flags(0), 3'b000);

      // 5b: pop in the push cycle of the fifth frame -> no overrun
      for (int i = 1; i <= 4; i++) begin
         send_frame(0, 8'(i), 0, 1'b0, 1'b1, 1'b0);
         sb_push(0, 8'(i));
      end
      send_frame(0, 8'h05, 0, 1'b0, 1'b1, 1'b1);
      sb_push(0, 8'h05);
      repeat (2) @(negedge clk);
      check("pp_flags", get_flags(0), 3'b000);
      check("pp_full", get_full(0), 1'b1);
      for (int i = 0; i < 4; i++) read_check(0, "pp_drain");
      check("pp_empty", get_valid(0), 1'b0);

      // 6: reset mid-frame
      send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1'b0);
      set_rx(0, 1'b0);
      repeat (CPB) @(negedge clk);
      set_rx(0, 1'b1);
      repeat (3 * CPB) @(negedge clk);
      check("mr_busy_before", get_busy(0), 1'b1);
      nRst = 1'b0;
      #1;
      check("mr_valid", get_valid(0), 1'b0);
      check("mr_data",  get_data(0), 8'h00);
      check("mr_full",  get_full(0), 1'b0);
      check("mr_busy",  get_busy(0), 1'b0);
      check("mr_flags", get_flags(0), 3'b000);
      exp0.delete();
      @(negedge clk);
      @(negedge clk);
      nRst = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("mr_idle_after", get_busy(0), 1'b0);
      check("mr_empty_after", get_valid(0), 1'b0);
      send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1'b0); sb_push(0, 8'h81);
      read_check(0, "mr_new");
      check("mr_only_one", get_valid(0), 1'b0);

      check("sb0_drained", exp0.size(), 0);
      check("sb1_drained", exp1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/t04_uart_rx_param.md
Name: t04_uart_rx_param

Overview:
- Parametrised UART receiver with a first-word-fall-through (FWFT) receive FIFO, driven from the board Rx pin inside t04_very_top.
- Replaces the fixed 8N1 receive path with configurable data width, parity mode, stop-bit count and buffering depth.
- Reports framing, parity and overrun errors through sticky flags.
- Runs on the single system clock and feeds the display/command logic through a read-strobe interface.

Parameters:
- CLKS_PER_BIT, 87, system clocks per UART bit; minimum 4.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits checked per frame: 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the rx_in synchroniser; at least 2.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- rx_in  in  1  asynchronous serial input; idles high.
- rd_en  in  1  pop the FIFO head; ignored when rd_valid=0.
- rd_data  out  DATA_BITS  FIFO head, valid while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- busy  out  1  state != IDLE.
- frame_err  out  1  sticky: a stop bit was sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: a good frame was dropped because the FIFO was full.
- clr_err  in  1  synchronous clear of all three sticky flags.

Behaviour:
Clock and reset:
- One clock (clk). Reset nRst is asynchronous and active-low.
- During reset:
  - synchroniser flops are forced to 1;
  - state=IDLE; bit counter and baud counter are 0;
  - FIFO is empty: rd_valid=0, fifo_full=0, rd_data=0;
  - busy=0, frame_err=0, parity_err=0, overrun=0.
- Reset mid-frame discards the partial frame.

Synchronisation:
- rx_in passes through SYNC_STAGES flops; call the result rxs.
- All logic below uses rxs only.

State machine (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE):
- IDLE:
  - rxs==0 -> START, baud counter loaded with CLKS_PER_BIT/2 - 1 (integer division).
- START:
  - At counter 0, sample rxs.
  - If 1: false start, return to IDLE, no flags set.
  - If 0: go to DATA, counter reloaded with CLKS_PER_BIT-1.
- DATA:
  - Sample at each counter expiry, LSB first, into a shift register.
  - After DATA_BITS samples go to PARITY if PARITY!=0, else to STOP.
- PARITY:
  - Sample the parity bit.
  - Mismatch latches pending_perr. Even mode: XOR of data and parity bit must be 0. Odd mode: it must be 1.
- STOP:
  - Sample STOP_BITS times, CLKS_PER_BIT apart.
  - Any low stop sample latches pending_ferr.
  - After the last stop sample, resolve the frame in the same cycle (see Frame resolution).
  - Then: if pending_ferr, go to WAIT_IDLE; else go directly to IDLE, so a start edge that immediately follows the mid-stop sample is still caught.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE.
  - Prevents a line break from retriggering frames.

Frame resolution:
- pending_ferr: set frame_err; no push.
- Else pending_perr: set parity_err; no push.
- Else push the payload.
  - If the FIFO is full and rd_en is not asserted in the same cycle: drop the payload and set overrun.
- Push is visible on rd_valid/rd_data one cycle after the last stop sample.
- Total latency from the start-bit falling edge at rxs to rd_valid: about (1.5 + DATA_BITS + parity + STOP_BITS - 1) bit times plus 1 clock.

FIFO:
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Simultaneous push and pop, including when full: both succeed, occupancy unchanged, no overrun.
- Pop when empty: no effect.

Sticky flags:
- Flags hold until clr_err.
- clr_err in the same cycle as a new error: the set wins.

Decomposition:
- Package t04_uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- Sub-module t04_sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, pop, din, dout, empty, full;
  - FWFT read; push and pop succeed together when full.
- Receiver FSM, baud counter and synchroniser remain in t04_uart_rx_param.

Test Plan (CLKS_PER_BIT=8, DATA_BITS=8, PARITY=0, STOP_BITS=1, FIFO_DEPTH=4 unless noted):
1. Send 0xA5 then 0x3C back-to-back, no idle gap -> rd_data=0xA5 with rd_valid=1; after rd_en, rd_data=0x3C; no error flags set.
2. Low pulse of 3 clocks on rx_in while idle -> START rejects it, busy returns to 0, FIFO stays empty, no flags set.
3. PARITY=1: send 0x07 with parity bit 1 -> pushed. Then 0x07 with parity bit 0 -> parity_err=1, FIFO holds only one entry. Pulse clr_err -> parity_err=0.
4. Send 0x55 with stop bit 0, then hold rx_in low for 30 bit times -> frame_err=1, no push, state stays WAIT_IDLE until rx_in goes high, then IDLE.
5. Send 5 frames 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, fifo_full=1, overrun=1. Repeat with rd_en pulsed in the push cycle of the 5th frame -> overrun stays 0, 0x05 is the last entry.
6. Assert nRst low mid-DATA of 0xFF, release, then send 0x81 -> only 0x81 appears, all outputs were 0 during reset.
